// File: rtl/sync_debounce_multi.sv
// sync_debounce_multi: CH-channel synchronizer chain, debounce filter and registered edge pulses.
// Optional per-channel busy output is compiled in when SYNC_DB_BUSY_EN is defined.
module sync_debounce_multi #(
    parameter int unsigned    CH          = 4,
    parameter int unsigned    SYNC_STAGES = 2,
    parameter int unsigned    DB_CYCLES   = 16,
    parameter logic [CH-1:0]  RESET_VAL   = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] async_in,
    output logic [CH-1:0] sync_out,
    output logic [CH-1:0] rise_pulse,
    output logic [CH-1:0] fall_pulse
`ifdef SYNC_DB_BUSY_EN
    ,
    output logic [CH-1:0] busy
`endif
);

    localparam int unsigned   CW       = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CH-1:0]         sync_q [SYNC_STAGES];
    logic [CH-1:0]         s_last;
    logic [CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CH-1:0]         level_q, level_d;
    logic [CH-1:0]         rise_q, rise_d;
    logic [CH-1:0]         fall_q, fall_d;

    // Synchronizer chain; the first stage is the only flop that may go metastable.
    // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= async_in;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s_last = sync_q[SYNC_STAGES-1];

    // Any agreement between the synchronized input and the level restarts qualification.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (s_last[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = s_last[i];
                    rise_d[i]  = s_last[i];
                    fall_d[i]  = ~s_last[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= RESET_VAL;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sync_out   = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef SYNC_DB_BUSY_EN
    logic [CH-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = '0;
        for (int i = 0; i < int'(CH); i++) begin
            busy_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`endif

endmodule

// File: tb/tb_sync_debounce_multi.sv
// Directed bench for sync_debounce_multi: expectations are queued per cycle as stimulus is driven.
// Instance A: SYNC_STAGES=2, DB_CYCLES=4, RESET_VAL=0. Instance B: DB_CYCLES=1, RESET_VAL=4'hA.
module tb_sync_debounce_multi;

    localparam int S_A = 0;
    localparam int R_A = 1;
    localparam int F_A = 2;
    localparam int B_A = 3;
    localparam int S_B = 4;
    localparam int R_B = 5;
    localparam int F_B = 6;

    typedef struct {
        string      tag;
        int         at;
        int         sel;
        logic [3:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a_in, b_in;
    logic [3:0] a_sync, a_rise, a_fall;
    logic [3:0] b_sync, b_rise, b_fall;
`ifdef SYNC_DB_BUSY_EN
    logic [3:0] a_busy, b_busy;
`endif

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_debounce_multi #(
        .CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .RESET_VAL(4'h0)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (a_in),
        .sync_out   (a_sync),
        .rise_pulse (a_rise),
        .fall_pulse (a_fall)
`ifdef SYNC_DB_BUSY_EN
        ,
        .busy       (a_busy)
`endif
    );

    sync_debounce_multi #(
        .CH(4), .SYNC_STAGES(2), .DB_CYCLES(1), .RESET_VAL(4'hA)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (b_in),
        .sync_out   (b_sync),
        .rise_pulse (b_rise),
        .fall_pulse (b_fall)
`ifdef SYNC_DB_BUSY_EN
        ,
        .busy       (b_busy)
`endif
    );

    function automatic logic [3:0] observe(int sel);
        case (sel)
            S_A:     return a_sync;
            R_A:     return a_rise;
            F_A:     return a_fall;
`ifdef SYNC_DB_BUSY_EN
            B_A:     return a_busy;
`endif
            S_B:     return b_sync;
            R_B:     return b_rise;
            F_B:     return b_fall;
            default: return 4'bxxxx;
        endcase
    endfunction

    // Queue one expected value per cycle for offsets [from, to] past the current edge.
    task automatic expw(input string tag, input int sel, input logic [3:0] val,
                        input int from, input int to);
        for (int k = from; k <= to; k++) begin
            exp_t e;
            e.tag = tag;
            e.at  = cyc + k;
            e.sel = sel;
            e.val = val;
            sb.push_back(e);
        end
    endtask

    task automatic check(input exp_t e);
        logic [3:0] o;
        o = observe(e.sel);
        checks++;
        assert (o === e.val) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", e.tag, cyc, o, e.val);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each and retiring due expectations.
    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    check(sb[i]);
                    sb.delete(i);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in  = 4'hF;
        b_in  = 4'hA;

        // Reset held for 3 edges with all inputs high.
        expw("rst_sync",  S_A, 4'h0, 1, 3);
        expw("rst_rise",  R_A, 4'h0, 1, 3);
        expw("rst_fall",  F_A, 4'h0, 1, 3);
`ifdef SYNC_DB_BUSY_EN
        expw("rst_busy",  B_A, 4'h0, 1, 3);
`endif
        expw("rst_sync_b", S_B, 4'hA, 1, 3);
        expw("rst_rise_b", R_B, 4'h0, 1, 3);
        step(3);

        // Release: all four channels qualify at edge 6.
        rst_n = 1'b1;
        expw("rel_sync_hold", S_A, 4'h0, 1, 5);
        expw("rel_sync_set",  S_A, 4'hF, 6, 7);
        expw("rel_rise_idle", R_A, 4'h0, 1, 5);
        expw("rel_rise",      R_A, 4'hF, 6, 6);
        expw("rel_rise_end",  R_A, 4'h0, 7, 7);
        expw("rel_fall",      F_A, 4'h0, 1, 7);
`ifdef SYNC_DB_BUSY_EN
        expw("rel_busy_lo",   B_A, 4'h0, 1, 2);
        expw("rel_busy_hi",   B_A, 4'hF, 3, 5);
        expw("rel_busy_end",  B_A, 4'h0, 6, 6);
`endif
        expw("rel_sync_b",    S_B, 4'hA, 1, 7);
        expw("rel_rise_b",    R_B, 4'h0, 1, 7);
        expw("rel_fall_b",    F_B, 4'h0, 1, 7);
        step(7);

        // All channels fall together.
        a_in = 4'h0;
        expw("fall_sync_hold", S_A, 4'hF, 1, 5);
        expw("fall_sync_clr",  S_A, 4'h0, 6, 8);
        expw("fall_idle",      F_A, 4'h0, 1, 5);
        expw("fall_pulse",     F_A, 4'hF, 6, 6);
        expw("fall_end",       F_A, 4'h0, 7, 8);
        expw("fall_no_rise",   R_A, 4'h0, 1, 8);
        step(8);

        // Clean rise on ch0.
        a_in = 4'h1;
        expw("ch0_sync_hold", S_A, 4'h0, 1, 5);
        expw("ch0_sync_set",  S_A, 4'h1, 6, 8);
        expw("ch0_rise_idle", R_A, 4'h0, 1, 5);
        expw("ch0_rise",      R_A, 4'h1, 6, 6);
        expw("ch0_rise_end",  R_A, 4'h0, 7, 8);
        expw("ch0_no_fall",   F_A, 4'h0, 1, 8);
        step(8);

        // ch1 high for exactly 3 cycles: one short of qualifying.
        a_in = 4'h3;
        expw("glitch_sync", S_A, 4'h1, 1, 8);
        expw("glitch_rise", R_A, 4'h0, 1, 8);
        expw("glitch_fall", F_A, 4'h0, 1, 8);
`ifdef SYNC_DB_BUSY_EN
        expw("glitch_busy_lo",  B_A, 4'h0, 1, 2);
        expw("glitch_busy_hi",  B_A, 4'h2, 3, 5);
        expw("glitch_busy_end", B_A, 4'h0, 6, 8);
`endif
        step(3);
        a_in = 4'h1;
        step(5);

        // ch2 rises; reset lands on edge 4 mid-count, then full re-qualification.
        a_in = 4'h5;
        expw("mid_sync_pre",   S_A, 4'h1, 1, 3);
        expw("mid_sync_rst",   S_A, 4'h0, 4, 9);
        expw("mid_sync_req",   S_A, 4'h5, 10, 11);
        expw("mid_rise_idle",  R_A, 4'h0, 1, 9);
        expw("mid_rise",       R_A, 4'h5, 10, 10);
        expw("mid_rise_end",   R_A, 4'h0, 11, 11);
        expw("mid_no_fall",    F_A, 4'h0, 1, 11);
`ifdef SYNC_DB_BUSY_EN
        expw("mid_busy_lo",    B_A, 4'h0, 1, 2);
        expw("mid_busy_cnt",   B_A, 4'h4, 3, 3);
        expw("mid_busy_rst",   B_A, 4'h0, 4, 6);
        expw("mid_busy_req",   B_A, 4'h5, 7, 9);
        expw("mid_busy_end",   B_A, 4'h0, 10, 10);
`endif
        expw("mid_sync_b",     S_B, 4'hA, 4, 4);
        step(3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(7);

        // Simultaneous opposite transitions on all channels.
        a_in = 4'hA;
        expw("sim_sync_hold", S_A, 4'h5, 1, 5);
        expw("sim_sync_set",  S_A, 4'hA, 6, 7);
        expw("sim_rise_idle", R_A, 4'h0, 1, 5);
        expw("sim_rise",      R_A, 4'hA, 6, 6);
        expw("sim_rise_end",  R_A, 4'h0, 7, 7);
        expw("sim_fall_idle", F_A, 4'h0, 1, 5);
        expw("sim_fall",      F_A, 4'h5, 6, 6);
        expw("sim_fall_end",  F_A, 4'h0, 7, 7);
`ifdef SYNC_DB_BUSY_EN
        expw("sim_busy_hi",   B_A, 4'hF, 3, 5);
        expw("sim_busy_end",  B_A, 4'h0, 6, 6);
`endif
        step(7);

        // ch0 toggling every cycle never qualifies.
        for (int t = 0; t < 12; t++) begin
            a_in[0] = ~a_in[0];
            expw("tog_sync", S_A, 4'hA, 1, 1);
            expw("tog_rise", R_A, 4'h0, 1, 1);
            expw("tog_fall", F_A, 4'h0, 1, 1);
            step(1);
        end
        a_in = 4'hA;
        expw("tog_settle_sync", S_A, 4'hA, 1, 6);
        expw("tog_settle_rise", R_A, 4'h0, 1, 6);
        step(6);

        // DB_CYCLES=1 instance: change visible after 3 edges with one-cycle pulses.
        b_in = 4'h5;
        expw("b_sync_hold", S_B, 4'hA, 1, 2);
        expw("b_sync_set",  S_B, 4'h5, 3, 4);
        expw("b_rise_idle", R_B, 4'h0, 1, 2);
        expw("b_rise",      R_B, 4'h5, 3, 3);
        expw("b_rise_end",  R_B, 4'h0, 4, 4);
        expw("b_fall_idle", F_B, 4'h0, 1, 2);
        expw("b_fall",      F_B, 4'hA, 3, 3);
        expw("b_fall_end",  F_B, 4'h0, 4, 4);
        step(4);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_debounce_multi.md
Name: sync_debounce_multi

Overview:
- Parametrised multi-channel successor to the two-flop input synchronizer.
- Brings CH independent asynchronous inputs (buttons, switches, external strobes) into the clk domain.
- Each channel has a configurable-depth synchronizer chain, a per-channel debounce filter, and registered rise/fall single-cycle pulses.
- Sits between top-level board pins and the control FSMs of the final-project datapath.

Parameters:
- CH, 4, number of independent channels (1..32).
- SYNC_STAGES, 2, synchronizer flop depth per channel (2..4).
- DB_CYCLES, 16, consecutive stable cycles required before the debounced level changes (1..65535).
- RESET_VAL, 0, CH-bit vector; reset value of sync chain and debounced level per channel.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- async_in  in  CH  asynchronous raw inputs
- sync_out  out  CH  synchronized, debounced level
- rise_pulse  out  CH  one-cycle pulse when sync_out goes 0->1
- fall_pulse  out  CH  one-cycle pulse when sync_out goes 1->0
- busy  out  CH  (SYNC_DB_BUSY_EN only) debounce counter running

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n, sampled at the posedge clk. All state is held in flops updated on posedge clk.
- Reset (rst_n=0 at an edge):
  - every sync flop and sync_out[i] <= RESET_VAL[i];
  - all counters <= 0;
  - rise_pulse, fall_pulse, busy <= 0.
  - Reset asserted mid-count discards that count; no pulse is generated by reset itself.
- Sync chain, per channel: stage0 <= async_in[i], stage k <= stage k-1. s_i denotes the last stage.
- Debounce, per channel, with counter cnt_i of width clog2(DB_CYCLES)+1:
  - s_i == sync_out[i]: cnt_i <= 0 (a glitch shorter than DB_CYCLES fully restarts the filter).
  - s_i != sync_out[i] and cnt_i < DB_CYCLES-1: cnt_i <= cnt_i+1.
  - s_i != sync_out[i] and cnt_i == DB_CYCLES-1: sync_out[i] <= s_i, cnt_i <= 0, and the matching pulse is driven high on the same edge.
- Latency: an async_in change that is stable before edge 0 first appears on s_i at edge SYNC_STAGES. sync_out changes at edge SYNC_STAGES+DB_CYCLES. DB_CYCLES=1 therefore gives a pure synchronizer plus one flop.
- Pulses:
  - registered; high exactly one cycle; rise and fall for the same channel are never high together;
  - otherwise 0 every cycle.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Input toggling every cycle: sync_out never changes and no pulses are produced.
- Counter never exceeds DB_CYCLES-1, so there is no wrap.

Optional Feature:
- Macro: SYNC_DB_BUSY_EN.
- Defined:
  - busy port exists;
  - busy[i] is registered, and is 1 on each cycle where cnt_i != 0 after the edge, i.e. the filter is mid-qualification;
  - reset value 0.
- Undefined: busy port and its logic are absent; all other behaviour is identical.

Test Plan (CH=4, SYNC_STAGES=2, DB_CYCLES=4, RESET_VAL=0 unless noted):
- Reset: hold rst_n=0 for 3 edges with async_in=4'hF -> sync_out=0, pulses=0, busy=0. Release -> sync_out[3:0]=4'hF at edge 6 after release, with rise_pulse=4'hF for that one cycle.
- Clean rise on ch0: async_in[0] 0->1 before edge 0 -> sync_out[0]=1 after edge 6; rise_pulse[0]=1 only in cycle 6; fall_pulse stays 0.
- Glitch reject: async_in[1]=1 for exactly 3 cycles, then 0 -> sync_out[1] stays 0; no pulses; busy[1] goes high then returns to 0.
- Mid-count reset: async_in[2] 0->1, assert rst_n=0 at edge 4 -> sync_out[2]=0 and cnt cleared. Re-qualification after release needs the full 6 edges.
- Simultaneous: async_in 4'b0000->4'b0101 then, after settling, 4'b1010 -> fall_pulse=4'b0101 and rise_pulse=4'b1010 in the same cycle.
- RESET_VAL=4'hA, DB_CYCLES=1: after reset sync_out=4'hA. An async_in change propagates in 3 edges with a single-cycle pulse.
